control_unit_pipe: RTL and testbench
====================================

Name: control_unit_pipe

Overview:
Parametrised next-generation instruction decoder for the quatrum datapath. It accepts instruction words over a valid/ready handshake and decodes them into registered datapath control words: register selects, ALU op, constant and data-bus drive. It adds a two-word long-immediate instruction, illegal-opcode detection and a retired-instruction counter. It sits between the instruction source and the register file/ALU.

Parameters:
DATA_W, 16, width of the datapath, const_in and data_in
REG_SEL_W, 4, width of each register select field
OP_W, 5, opcode field width
INSTR_W, 32, instruction word width; must be >= OP_W + 2*REG_SEL_W + DATA_W
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
instr  in  INSTR_W  instruction word
instr_valid  in  1  instr is valid
instr_ready  out  1  decoder accepts instr this cycle
ctrl_valid  out  1  control word valid
ctrl_ready  in  1  datapath consumes control word
load_en  out  1  register write enable
dest_sel  out  REG_SEL_W  destination register
A_sel  out  REG_SEL_W  ALU A operand register
B_sel  out  REG_SEL_W  ALU B operand register
op_sel  out  4  ALU operation
const_in  out  DATA_W  constant to the B mux
const_sel  out  1  1 = B operand from const_in
data_in  out  DATA_W  data driven to the register write mux
data_sel  out  1  1 = write data from data_in
illegal  out  1  one-cycle pulse, decoded word had an illegal opcode
illegal_seen  out  1  sticky flag for illegal opcodes
retired  out  CNT_W  count of completed ctrl handshakes

Behaviour:
- Fields, MSB-first: op = instr[INSTR_W-1 -: OP_W]; f1, f2, f3 = the next three REG_SEL_W slices; imm = DATA_W bits directly below f2.
- Reset values: every output 0, including ctrl_valid, retired and illegal_seen. State goes to S_OP. Reset mid-ldl discards the latched dest.
- Handshakes:
  - instr_ready = !ctrl_valid || ctrl_ready.
  - Accept = instr_valid && instr_ready.
  - Issue = ctrl_valid && ctrl_ready.
  - While ctrl_valid && !ctrl_ready, all control outputs hold stable.
- States:
  - S_OP: on accept, decode op.
    - ldl: latch f1, go to S_IMM, no control word issued.
    - Any other op: register the control word, ctrl_valid=1 next cycle (latency 1).
    - No accept: ctrl_valid clears after issue.
  - S_IMM: on accept, the whole word is the immediate. Issue load_en=1, data_sel=1, data_in=instr[DATA_W-1:0], dest_sel=latched f1, const_sel=0, op_sel=0. Return to S_OP.
- Decode table. Unless stated otherwise: load_en=1, data_sel=0, const_sel=0, A=f1, B=f2, dest=f3. Unassigned selects drive 0.
  - 0 nop: load_en=0.
  - 1 mova: A=f1, dest=f3, const_sel=1, const_in=0, op=0101.
  - 2 add 0000; 3 sub 0001; 4 and 0100; 5 or 0101; 6 xor 0110; 7 not 0111.
  - 8 adi 0000; 9 sbi 0001; 10 ani 0100; 11 ori 0101; 12 xri 0110. For all five: A=f1, dest=f2, const_sel=1, const_in=imm.
  - 13 movb: A=f1, B=f1, dest=f3, op=0101.
  - 14 lsr 1001; 15 lsl 1000.
  - 16 ldl: two-word instruction (see S_IMM).
  - 17..2^OP_W-1 illegal: control word issued with load_en=0, illegal=1 for one cycle, illegal_seen set until reset.
- retired: increments by 1 per issue, including nop and illegal. Wraps 2^CNT_W-1 -> 0.
- instr_valid low in S_IMM: wait indefinitely, no timeout.

Test Plan:
- Reset, then add f1=3 f2=5 f3=7 with ctrl_ready=1 -> next cycle ctrl_valid=1, A=3, B=5, dest=7, op=0000, load_en=1, const_sel=0; retired=1.
- adi f1=2 f2=9 imm=16'h1234 -> A=2, dest=9, const_sel=1, const_in=16'h1234, op=0000.
- ldl f1=4, then word 32'h0000ABCD -> no ctrl_valid after the first word; after the second, data_sel=1, data_in=16'hABCD, dest=4, load_en=1.
- ctrl_ready=0 for 3 cycles with an issued sub -> outputs stable, instr_ready=0; release -> issue once, retired+1.
- op=20 -> illegal pulses one cycle, load_en=0, illegal_seen stays 1; assert rst -> all outputs 0.
- ldl first word, rst, then add -> add decoded normally with dest=f3; no stale ldl.

Source files
------------

// File: rtl/control_unit_pipe.sv
// Instruction decoder: valid/ready in, registered datapath control word out.
// Supports two-word ldl (long immediate), illegal-opcode flagging and a retired counter.
module control_unit_pipe #(
  parameter int DATA_W    = 16,
  parameter int REG_SEL_W = 4,
  parameter int OP_W      = 5,
  parameter int INSTR_W   = 32,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [INSTR_W-1:0]   instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic                 ctrl_valid,
  input  logic                 ctrl_ready,
  output logic                 load_en,
  output logic [REG_SEL_W-1:0] dest_sel,
  output logic [REG_SEL_W-1:0] A_sel,
  output logic [REG_SEL_W-1:0] B_sel,
  output logic [3:0]           op_sel,
  output logic [DATA_W-1:0]    const_in,
  output logic                 const_sel,
  output logic [DATA_W-1:0]    data_in,
  output logic                 data_sel,
  output logic                 illegal,
  output logic                 illegal_seen,
  output logic [CNT_W-1:0]     retired
);

  localparam int F1_LSB  = INSTR_W - OP_W - REG_SEL_W;
  localparam int F2_LSB  = F1_LSB - REG_SEL_W;
  localparam int F3_LSB  = F2_LSB - REG_SEL_W;
  localparam int IMM_LSB = F2_LSB - DATA_W;

  typedef enum logic {S_OP, S_IMM} state_t;

  state_t                 state_q, state_d;
  logic                   ctrl_valid_q, ctrl_valid_d;
  logic                   load_en_q, load_en_d;
  logic [REG_SEL_W-1:0]   dest_q, dest_d, a_q, a_d, b_q, b_d, ldl_dest_q, ldl_dest_d;
  logic [3:0]             op_sel_q, op_sel_d;
  logic [DATA_W-1:0]      const_in_q, const_in_d, data_in_q, data_in_d;
  logic                   const_sel_q, const_sel_d, data_sel_q, data_sel_d;
  logic                   illegal_q, illegal_d, illegal_seen_q, illegal_seen_d;
  logic [CNT_W-1:0]       retired_q, retired_d;

  logic [OP_W-1:0]        op;
  logic [REG_SEL_W-1:0]   f1, f2, f3;
  logic [DATA_W-1:0]      imm;
  logic                   accept, issue;

  assign op  = instr[INSTR_W-1 -: OP_W];
  assign f1  = instr[F1_LSB +: REG_SEL_W];
  assign f2  = instr[F2_LSB +: REG_SEL_W];
  assign f3  = instr[F3_LSB +: REG_SEL_W];
  assign imm = instr[IMM_LSB +: DATA_W];

  assign instr_ready = !ctrl_valid_q || ctrl_ready;
  assign accept      = instr_valid && instr_ready;
  assign issue       = ctrl_valid_q && ctrl_ready;

  always_comb begin
    state_d        = state_q;
    ctrl_valid_d   = ctrl_valid_q;
    load_en_d      = load_en_q;
    dest_d         = dest_q;
    a_d            = a_q;
    b_d            = b_q;
    ldl_dest_d     = ldl_dest_q;
    op_sel_d       = op_sel_q;
    const_in_d     = const_in_q;
    const_sel_d    = const_sel_q;
    data_in_d      = data_in_q;
    data_sel_d     = data_sel_q;
    illegal_d      = 1'b0;
    illegal_seen_d = illegal_seen_q;
    retired_d      = retired_q;

    if (issue) begin
      ctrl_valid_d = 1'b0;
      retired_d    = retired_q + CNT_W'(1);
    end

    if (accept) begin
      if (state_q == S_IMM) begin
        ctrl_valid_d = 1'b1;
        load_en_d    = 1'b1;
        dest_d       = ldl_dest_q;
        a_d          = '0;
        b_d          = '0;
        op_sel_d     = 4'b0000;
        const_in_d   = '0;
        const_sel_d  = 1'b0;
        data_in_d    = instr[DATA_W-1:0];
        data_sel_d   = 1'b1;
        state_d      = S_OP;
      end else if (op == OP_W'(16)) begin
        // First ldl word only captures the destination; nothing is issued yet.
        ldl_dest_d = f1;
        state_d    = S_IMM;
      end else begin
        ctrl_valid_d = 1'b1;
        load_en_d    = 1'b1;
        a_d          = f1;
        b_d          = f2;
        dest_d       = f3;
        op_sel_d     = 4'b0000;
        const_in_d   = '0;
        const_sel_d  = 1'b0;
        data_in_d    = '0;
        data_sel_d   = 1'b0;
        case (op)
          OP_W'(0):  load_en_d = 1'b0;
          OP_W'(1):  begin b_d = '0; const_sel_d = 1'b1; op_sel_d = 4'b0101; end
          OP_W'(2):  op_sel_d = 4'b0000;
          OP_W'(3):  op_sel_d = 4'b0001;
          OP_W'(4):  op_sel_d = 4'b0100;
          OP_W'(5):  op_sel_d = 4'b0101;
          OP_W'(6):  op_sel_d = 4'b0110;
          OP_W'(7):  op_sel_d = 4'b0111;
          OP_W'(8), OP_W'(9), OP_W'(10), OP_W'(11), OP_W'(12): begin
            b_d         = '0;
            dest_d      = f2;
            const_sel_d = 1'b1;
            const_in_d  = imm;
            op_sel_d    = (op == OP_W'(8))  ? 4'b0000 :
                          (op == OP_W'(9))  ? 4'b0001 :
                          (op == OP_W'(10)) ? 4'b0100 :
                          (op == OP_W'(11)) ? 4'b0101 : 4'b0110;
          end
          OP_W'(13): begin b_d = f1; op_sel_d = 4'b0101; end
          OP_W'(14): op_sel_d = 4'b1001;
          OP_W'(15): op_sel_d = 4'b1000;
          default: begin
            load_en_d      = 1'b0;
            illegal_d      = 1'b1;
            illegal_seen_d = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_OP;
      ctrl_valid_q   <= 1'b0;
      load_en_q      <= 1'b0;
      dest_q         <= '0;
      a_q            <= '0;
      b_q            <= '0;
      ldl_dest_q     <= '0;
      op_sel_q       <= '0;
      const_in_q     <= '0;
      const_sel_q    <= 1'b0;
      data_in_q      <= '0;
      data_sel_q     <= 1'b0;
      illegal_q      <= 1'b0;
      illegal_seen_q <= 1'b0;
      retired_q      <= '0;
    end else begin
      state_q        <= state_d;
      ctrl_valid_q   <= ctrl_valid_d;
      load_en_q      <= load_en_d;
      dest_q         <= dest_d;
      a_q            <= a_d;
      b_q            <= b_d;
      ldl_dest_q     <= ldl_dest_d;
      op_sel_q       <= op_sel_d;
      const_in_q     <= const_in_d;
      const_sel_q    <= const_sel_d;
      data_in_q      <= data_in_d;
      data_sel_q     <= data_sel_d;
      illegal_q      <= illegal_d;
      illegal_seen_q <= illegal_seen_d;
      retired_q      <= retired_d;
    end
  end

  assign ctrl_valid   = ctrl_valid_q;
  assign load_en      = load_en_q;
  assign dest_sel     = dest_q;
  assign A_sel        = a_q;
  assign B_sel        = b_q;
  assign op_sel       = op_sel_q;
  assign const_in     = const_in_q;
  assign const_sel    = const_sel_q;
  assign data_in      = data_in_q;
  assign data_sel     = data_sel_q;
  assign illegal      = illegal_q;
  assign illegal_seen = illegal_seen_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed self-checking bench for control_unit_pipe (default parameters).
module tb_control_unit_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid, instr_ready, ctrl_valid, ctrl_ready;
  logic        load_en, const_sel, data_sel, illegal, illegal_seen;
  logic [3:0]  dest_sel, A_sel, B_sel, op_sel;
  logic [15:0] const_in, data_in, retired;

  int checks = 0;
  int passed = 0;

  control_unit_pipe dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .load_en(load_en), .dest_sel(dest_sel), .A_sel(A_sel), .B_sel(B_sel),
    .op_sel(op_sel), .const_in(const_in), .const_sel(const_sel),
    .data_in(data_in), .data_sel(data_sel), .illegal(illegal),
    .illegal_seen(illegal_seen), .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int op, input int f1, input int f2, input int f3);
    return {op[4:0], f1[3:0], f2[3:0], f3[3:0], 15'd0};
  endfunction

  function automatic logic [31:0] mki(input int op, input int f1, input int f2, input int imm);
    return {op[4:0], f1[3:0], f2[3:0], imm[15:0], 3'd0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; ctrl_ready = 1'b0;
    step(); step();
    chk("rst_ctrl_valid", ctrl_valid, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal_seen", illegal_seen, 0);
    chk("rst_load_en", load_en, 0);
    rst = 1'b0; ctrl_ready = 1'b1;

    // add f1=3 f2=5 f3=7
    instr = mk(2, 3, 5, 7); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("add_valid", ctrl_valid, 1);
    chk("add_A", A_sel, 3);
    chk("add_B", B_sel, 5);
    chk("add_dest", dest_sel, 7);
    chk("add_op", op_sel, 4'b0000);
    chk("add_load", load_en, 1);
    chk("add_csel", const_sel, 0);
    step();
    chk("add_retired", retired, 1);
    chk("add_valid_clr", ctrl_valid, 0);

    // adi f1=2 f2=9 imm=1234
    instr = mki(8, 2, 9, 16'h1234); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("adi_A", A_sel, 2);
    chk("adi_B", B_sel, 0);
    chk("adi_dest", dest_sel, 9);
    chk("adi_csel", const_sel, 1);
    chk("adi_const", const_in, 16'h1234);
    chk("adi_op", op_sel, 4'b0000);
    step();

    // xri f1=1 f2=6 imm=00F0
    instr = mki(12, 1, 6, 16'h00F0); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("xri_op", op_sel, 4'b0110);
    chk("xri_const", const_in, 16'h00F0);
    chk("xri_dest", dest_sel, 6);
    step();

    // mova f1=5 f3=11
    instr = mk(1, 5, 2, 11); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("mova_op", op_sel, 4'b0101);
    chk("mova_B", B_sel, 0);
    chk("mova_csel", const_sel, 1);
    chk("mova_const", const_in, 0);
    chk("mova_dest", dest_sel, 11);
    step();

    // movb f1=6
    instr = mk(13, 6, 1, 2); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("movb_B", B_sel, 6);
    chk("movb_op", op_sel, 4'b0101);
    step();

    // lsr / nop back to back
    instr = mk(14, 1, 2, 3); instr_valid = 1'b1;
    step();
    chk("lsr_op", op_sel, 4'b1001);
    instr = mk(0, 1, 2, 3);
    step();
    instr_valid = 1'b0;
    chk("nop_load", load_en, 0);
    chk("nop_valid", ctrl_valid, 1);
    step();
    chk("nop_retired", retired, 7);

    // ldl f1=4, immediate ABCD
    instr = mk(16, 4, 0, 0); instr_valid = 1'b1;
    step();
    chk("ldl1_no_valid", ctrl_valid, 0);
    instr = 32'h0000ABCD;
    step();
    instr_valid = 1'b0;
    chk("ldl_valid", ctrl_valid, 1);
    chk("ldl_dsel", data_sel, 1);
    chk("ldl_data", data_in, 16'hABCD);
    chk("ldl_dest", dest_sel, 4);
    chk("ldl_load", load_en, 1);
    chk("ldl_csel", const_sel, 0);
    step();
    chk("ldl_retired", retired, 8);

    // back-pressure on sub
    ctrl_ready = 1'b0;
    instr = mk(3, 1, 2, 3); instr_valid = 1'b1;
    step();
    chk("sub_op", op_sel, 4'b0001);
    instr = mk(6, 9, 9, 9);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", ctrl_valid, 1);
      chk("stall_op", op_sel, 4'b0001);
      chk("stall_A", A_sel, 1);
      chk("stall_ready", instr_ready, 0);
      chk("stall_retired", retired, 8);
    end
    instr_valid = 1'b0; ctrl_ready = 1'b1;
    #1;
    chk("release_ready", instr_ready, 1);
    step();
    chk("release_valid", ctrl_valid, 0);
    chk("release_retired", retired, 9);
    step();
    chk("release_once", retired, 9);

    // illegal opcode 20
    instr = mk(20, 1, 2, 3); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_load", load_en, 0);
    chk("ill_valid", ctrl_valid, 1);
    chk("ill_seen", illegal_seen, 1);
    step();
    chk("ill_pulse_clr", illegal, 0);
    chk("ill_seen_hold", illegal_seen, 1);
    chk("ill_retired", retired, 10);
    step();
    chk("ill_seen_hold2", illegal_seen, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_seen", illegal_seen, 0);
    chk("rst2_retired", retired, 0);
    chk("rst2_dest", dest_sel, 0);
    chk("rst2_op", op_sel, 0);
    chk("rst2_valid", ctrl_valid, 0);

    // ldl interrupted by reset must not leak into next add
    instr = mk(16, 9, 0, 0); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    instr = mk(2, 1, 2, 6); instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
    chk("post_rst_valid", ctrl_valid, 1);
    chk("post_rst_dest", dest_sel, 6);
    chk("post_rst_dsel", data_sel, 0);
    chk("post_rst_A", A_sel, 1);
    step();
    chk("post_rst_retired", retired, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
